// File: rtl/id_pipe_decoder.sv
// id_pipe_decoder: instruction-decode stage for the 16-bit MIPS-style core.
// Accepts instructions on a valid/ready handshake and registers the decoded fields and
// control strobes in a one-entry output bundle. A register scoreboard tracks pending writes.
// Fetch is stalled on read-after-write hazards. The decoder halts after OP_END until flush_i.
// Optional build macro ID_WB_BYPASS_EN: a write-back in the current cycle releases a stall
// in that same cycle.
module id_pipe_decoder #(
    parameter int unsigned IW  = 16,
    parameter int unsigned RAW = 4
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [IW-1:0]     instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [3:0]        dec_op_o,
    output logic [RAW-1:0]    dec_rd_o,
    output logic [RAW-1:0]    dec_ra_o,
    output logic [RAW-1:0]    dec_rb_o,
    output logic [IW-5-RAW:0] dec_imm_o,
    output logic [IW-5:0]     dec_tgt_o,
    output logic [5:0]        dec_ctl_o,
    input  logic              wb_en_i,
    input  logic [RAW-1:0]    wb_adr_i,
    input  logic              flush_i,
    output logic              haz_o,
    output logic              end_pr_o
);

    localparam int unsigned NREG = 2 ** RAW;

    localparam logic [3:0] OpNop = 4'd0;
    localparam logic [3:0] OpIn  = 4'd1;
    localparam logic [3:0] OpWr  = 4'd2;
    localparam logic [3:0] OpJmp = 4'd3;
    localparam logic [3:0] OpJn  = 4'd4;
    localparam logic [3:0] OpJr  = 4'd5;
    localparam logic [3:0] OpEnd = 4'd15;

    // Control bundle order: {alu, mem_rd, mem_wr, jmp, jn, jr}
    localparam logic [5:0] CtlAlu = 6'b100000;
    localparam logic [5:0] CtlIn  = 6'b010000;
    localparam logic [5:0] CtlWr  = 6'b001000;
    localparam logic [5:0] CtlJmp = 6'b000100;
    localparam logic [5:0] CtlJn  = 6'b000010;
    localparam logic [5:0] CtlJr  = 6'b000001;

    typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

    state_e state_q, state_d;

    // Raw field split of the offered instruction
    logic [3:0]        in_op;
    logic [RAW-1:0]    in_rd, in_ra, in_rb;
    logic [IW-5-RAW:0] in_imm;
    logic [IW-5:0]     in_tgt;

    assign in_op  = instr_i[IW-1 -: 4];
    assign in_rd  = instr_i[IW-5 -: RAW];
    assign in_ra  = instr_i[IW-5-RAW -: RAW];
    assign in_rb  = instr_i[IW-5-2*RAW -: RAW];
    assign in_imm = instr_i[IW-5-RAW:0];
    assign in_tgt = instr_i[IW-5:0];

    logic [NREG-1:0] rd_oh, ra_oh, rb_oh, wb_oh;

    assign rd_oh = NREG'(1) << in_rd;
    assign ra_oh = NREG'(1) << in_ra;
    assign rb_oh = NREG'(1) << in_rb;
    assign wb_oh = wb_en_i ? (NREG'(1) << wb_adr_i) : '0;

    logic [5:0]      in_ctl;
    logic [NREG-1:0] src_mask;
    logic            writes_rd;

    // Opcode decode: control strobes, source registers read, destination write
    always_comb begin
        in_ctl    = '0;
        src_mask  = '0;
        writes_rd = 1'b0;
        case (in_op)
            OpNop, OpEnd: ;
            OpIn: begin
                in_ctl    = CtlIn;
                writes_rd = 1'b1;
            end
            OpWr: begin
                in_ctl   = CtlWr;
                src_mask = rd_oh;
            end
            OpJmp: in_ctl = CtlJmp;
            OpJn: begin
                in_ctl   = CtlJn;
                src_mask = ra_oh | rb_oh;
            end
            OpJr: begin
                in_ctl   = CtlJr;
                src_mask = ra_oh | rb_oh;
            end
            default: begin
                in_ctl    = CtlAlu;
                src_mask  = ra_oh | rb_oh;
                writes_rd = 1'b1;
            end
        endcase
    end

    logic [NREG-1:0] sb_q, sb_d, sb_eff;
    logic            hz;
    logic            rdy;
    logic            accept;

`ifdef ID_WB_BYPASS_EN
    // A register retiring this cycle no longer blocks its readers
    assign sb_eff = sb_q & ~wb_oh;
`else
    assign sb_eff = sb_q;
`endif

    assign hz     = instr_valid_i && (|(src_mask & sb_eff));
    assign accept = instr_valid_i && rdy;

    // Scoreboard next state: clear on write-back, then set on accept so set wins
    always_comb begin
        sb_d = sb_q;
        if (wb_en_i && (wb_adr_i != '0)) begin
            sb_d = sb_d & ~wb_oh;
        end
        if (accept && writes_rd && (in_rd != '0)) begin
            sb_d = sb_d | rd_oh;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush dominates, an accepted END halts, a blocked source stalls
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun, StStall: begin
                if (flush_i) begin
                    state_d = StRun;
                end else if (accept && (in_op == OpEnd)) begin
                    state_d = StHalt;
                end else if (hz) begin
                    state_d = StStall;
                end else begin
                    state_d = StRun;
                end
            end
            StHalt: begin
                if (flush_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs: ready needs a free bundle slot, no hazard, no flush and no halt
    always_comb begin
        haz_o    = (state_q == StStall);
        end_pr_o = (state_q == StHalt);
        rdy      = (state_q != StHalt) && !flush_i && !hz && (!dec_valid_o || dec_ready_i);
    end

    // Ready is held low while reset is asserted; kept off the internal accept path
    assign instr_ready_o = rdy && rst_n;

    // Output bundle: load on accept, hold under back-pressure, drop on consume or flush
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_o <= 1'b0;
            dec_op_o    <= '0;
            dec_rd_o    <= '0;
            dec_ra_o    <= '0;
            dec_rb_o    <= '0;
            dec_imm_o   <= '0;
            dec_tgt_o   <= '0;
            dec_ctl_o   <= '0;
        end else if (flush_i) begin
            dec_valid_o <= 1'b0;
        end else if (accept) begin
            dec_valid_o <= 1'b1;
            dec_op_o    <= in_op;
            dec_rd_o    <= in_rd;
            dec_ra_o    <= in_ra;
            dec_rb_o    <= in_rb;
            dec_imm_o   <= in_imm;
            dec_tgt_o   <= in_tgt;
            dec_ctl_o   <= in_ctl;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule
